// File: rtl/ksa_shuffle.sv
// RC4 key-scheduling shuffle: swaps S[i] and S[j] for i=0..255 through a shared single-port memory handshake.
// Latency: 256*(4*(N+1)+2) cycles for an N-cycle memory; backpressure comes only from finish_readWrite_op.
module ksa_shuffle #(
    parameter int KEY_LEN = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [8*KEY_LEN-1:0]   secret_key,
    output logic [7:0]             address,
    output logic [7:0]             data_out,
    input  logic [7:0]             data_in,
    output logic                   readWrite,
    output logic                   start_readWrite_op,
    input  logic                   finish_readWrite_op,
    input  logic                   start_ksa,
    output logic                   finish_ksa
);

    localparam int KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

    typedef enum logic [3:0] {
        IDLE, RD_SI, WT_SI, CALC_J, RD_SJ, WT_SJ,
        WR_SI, WT_WSI, WR_SJ, WT_WSJ, INCR, FINISH
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
    logic [KW-1:0]   kidx_q, kidx_d;
    logic [7:0]      address_q, address_d, data_out_q, data_out_d;
    logic            readWrite_q, readWrite_d;
    logic            start_op_q, start_op_d;
    logic            finish_ksa_q, finish_ksa_d;
    logic [7:0]      key_byte;

    // Key byte 0 sits in the most significant byte of secret_key.
    always_comb begin
        key_byte = 8'h00;
        for (int k = 0; k < KEY_LEN; k++) begin
            if (kidx_q == KW'(k)) begin
                key_byte = secret_key[8*(KEY_LEN-1-k) +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        j_d          = j_q;
        si_d         = si_q;
        sj_d         = sj_q;
        kidx_d       = kidx_q;
        address_d    = address_q;
        data_out_d   = data_out_q;
        readWrite_d  = readWrite_q;
        start_op_d   = 1'b0;
        finish_ksa_d = 1'b0;

        case (state_q)
            IDLE: begin
                i_d    = 8'h00;
                j_d    = 8'h00;
                kidx_d = '0;
                if (start_ksa) state_d = RD_SI;
            end
            RD_SI:  state_d = WT_SI;
            WT_SI: begin
                if (finish_readWrite_op) begin
                    si_d    = data_in;
                    state_d = CALC_J;
                end
            end
            CALC_J: begin
                j_d     = j_q + si_q + key_byte;
                state_d = RD_SJ;
            end
            RD_SJ:  state_d = WT_SJ;
            WT_SJ: begin
                if (finish_readWrite_op) begin
                    sj_d    = data_in;
                    state_d = WR_SI;
                end
            end
            WR_SI:  state_d = WT_WSI;
            WT_WSI: if (finish_readWrite_op) state_d = WR_SJ;
            WR_SJ:  state_d = WT_WSJ;
            WT_WSJ: if (finish_readWrite_op) state_d = INCR;
            INCR: begin
                if (i_q == 8'hFF) begin
                    state_d = FINISH;
                end else begin
                    i_d     = i_q + 8'h01;
                    kidx_d  = (kidx_q == KW'(KEY_LEN-1)) ? '0 : kidx_q + KW'(1);
                    state_d = RD_SI;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered on entry to a state, so the issuing state shows the request in its own cycle.
        case (state_d)
            IDLE, FINISH: begin
                address_d    = 8'h00;
                data_out_d   = 8'h00;
                readWrite_d  = 1'b0;
                finish_ksa_d = (state_d == FINISH);
            end
            RD_SI: begin
                address_d   = i_d;
                readWrite_d = 1'b0;
                start_op_d  = 1'b1;
            end
            RD_SJ: begin
                address_d   = j_d;
                readWrite_d = 1'b0;
                start_op_d  = 1'b1;
            end
            WR_SI: begin
                address_d   = i_d;
                data_out_d  = sj_d;
                readWrite_d = 1'b1;
                start_op_d  = 1'b1;
            end
            WR_SJ: begin
                address_d   = j_d;
                data_out_d  = si_d;
                readWrite_d = 1'b1;
                start_op_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            i_q          <= 8'h00;
            j_q          <= 8'h00;
            si_q         <= 8'h00;
            sj_q         <= 8'h00;
            kidx_q       <= '0;
            address_q    <= 8'h00;
            data_out_q   <= 8'h00;
            readWrite_q  <= 1'b0;
            start_op_q   <= 1'b0;
            finish_ksa_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            j_q          <= j_d;
            si_q         <= si_d;
            sj_q         <= sj_d;
            kidx_q       <= kidx_d;
            address_q    <= address_d;
            data_out_q   <= data_out_d;
            readWrite_q  <= readWrite_d;
            start_op_q   <= start_op_d;
            finish_ksa_q <= finish_ksa_d;
        end
    end

    assign address            = address_q;
    assign data_out           = data_out_q;
    assign readWrite          = readWrite_q;
    assign start_readWrite_op = start_op_q;
    assign finish_ksa         = finish_ksa_q;

endmodule

// File: tb/tb_ksa_shuffle.sv
// Bench for ksa_shuffle: mock S memory with configurable latency, software KSA reference, protocol monitor.
module tb_ksa_shuffle;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b0;
    logic        start_ksa = 1'b0;
    logic        sel = 1'b0;
    logic [23:0] key3 = 24'h000249;
    logic [7:0]  key1 = 8'hFF;
    logic [7:0]  a3, d3, a1, d1;
    logic        rw3, st3, fk3, rw1, st1, fk1;
    logic        f3, f1, sk3, sk1;
    logic [7:0]  m_din = 8'h00;
    logic        m_fin = 1'b0;
    logic [7:0]  m_addr, m_dout;
    logic        m_rw, m_start, m_finksa;

    assign m_addr   = sel ? a1  : a3;
    assign m_dout   = sel ? d1  : d3;
    assign m_rw     = sel ? rw1 : rw3;
    assign m_start  = sel ? st1 : st3;
    assign m_finksa = sel ? fk1 : fk3;
    assign f3  = sel ? 1'b0 : m_fin;
    assign f1  = sel ? m_fin : 1'b0;
    assign sk3 = sel ? 1'b0 : start_ksa;
    assign sk1 = sel ? start_ksa : 1'b0;

    ksa_shuffle #(.KEY_LEN(3)) dut3 (
        .clk(clk), .reset(reset), .secret_key(key3), .address(a3), .data_out(d3),
        .data_in(m_din), .readWrite(rw3), .start_readWrite_op(st3),
        .finish_readWrite_op(f3), .start_ksa(sk3), .finish_ksa(fk3));

    ksa_shuffle #(.KEY_LEN(1)) dut1 (
        .clk(clk), .reset(reset), .secret_key(key1), .address(a1), .data_out(d1),
        .data_in(m_din), .readWrite(rw1), .start_readWrite_op(st1),
        .finish_readWrite_op(f1), .start_ksa(sk1), .finish_ksa(fk1));

    int n_cmp = 0;
    int n_fail = 0;

    // Mock memory and protocol monitor state.
    logic [7:0] mem [256];
    int         gold [256];
    int         key_b [16];
    int         lat_mode = 2;
    bit         mon_en = 1'b1;
    bit         pend = 1'b0;
    int         cnt = 0;
    logic [7:0] cap_a = 8'h00, cap_d = 8'h00;
    logic       cap_rw = 1'b0;
    int         cyc = 0;
    int         viol = 0, start_cnt = 0, fin_cnt = 0, fin_wid_bad = 0, fin_deliv = 0;
    bit         prev_fk = 1'b0;
    int         start_cyc_q [$];
    int         fin_cyc_q [$];
    logic [7:0] wq_a [$];
    logic [7:0] wq_d [$];

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (m_fin) begin
            m_fin = 1'b0;
            pend  = 1'b0;
        end
        if (m_start === 1'b1) begin
            if (pend && mon_en) viol++;
            start_cnt++;
            start_cyc_q.push_back(cyc);
            cap_a  = m_addr;
            cap_d  = m_dout;
            cap_rw = m_rw;
            cnt    = (lat_mode == 0) ? int'($urandom_range(6, 1)) : lat_mode;
            pend   = 1'b1;
            if (m_rw) begin
                wq_a.push_back(m_addr);
                wq_d.push_back(m_dout);
            end
        end else if (pend) begin
            if (mon_en && (m_addr !== cap_a || m_dout !== cap_d || m_rw !== cap_rw)) viol++;
            cnt--;
            if (cnt == 0) begin
                m_fin = 1'b1;
                fin_deliv++;
                if (cap_rw) mem[cap_a] = cap_d;
                else        m_din = mem[cap_a];
            end
        end
        if (m_finksa === 1'b1) begin
            fin_cnt++;
            fin_cyc_q.push_back(cyc);
            if (prev_fk) fin_wid_bad++;
        end
        prev_fk = (m_finksa === 1'b1);
    end

    task automatic init_identity();
        for (int k = 0; k < 256; k++) begin
            mem[k]  = 8'(k);
            gold[k] = k;
        end
    endtask

    task automatic clear_stats();
        viol = 0; start_cnt = 0; fin_cnt = 0; fin_wid_bad = 0; fin_deliv = 0;
        start_cyc_q.delete(); fin_cyc_q.delete(); wq_a.delete(); wq_d.delete();
    endtask

    // Reference KSA: plain array arithmetic over the key bytes.
    task automatic gold_ksa(input int klen);
        int j = 0;
        int t;
        for (int i = 0; i < 256; i++) begin
            j = (j + gold[i] + key_b[i % klen]) % 256;
            t = gold[i]; gold[i] = gold[j]; gold[j] = t;
        end
    endtask

    function automatic int s_diff();
        int bad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== 8'(gold[k])) bad++;
        return bad;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start_ksa = 1'b1;
        @(negedge clk);
        start_ksa = 1'b0;
    endtask

    task automatic wait_fin(input int n, input string name);
        int c = 0;
        while (fin_cnt < n && c < 20000) begin
            @(negedge clk); #1;
            c++;
        end
        n_cmp++;
        if (fin_cnt < n) begin
            n_fail++;
            $display("FAIL %s timeout: finish_ksa count %0d, required %0d", name, fin_cnt, n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            n_cmp++; if (m_addr !== 8'h00)  begin n_fail++; $display("FAIL reset_address sel%0d: got %h, need 00", s, m_addr); end
            n_cmp++; if (m_dout !== 8'h00)  begin n_fail++; $display("FAIL reset_data_out sel%0d: got %h, need 00", s, m_dout); end
            n_cmp++; if (m_rw !== 1'b0)     begin n_fail++; $display("FAIL reset_readWrite sel%0d: got %b, need 0", s, m_rw); end
            n_cmp++; if (m_start !== 1'b0)  begin n_fail++; $display("FAIL reset_start_op sel%0d: got %b, need 0", s, m_start); end
            n_cmp++; if (m_finksa !== 1'b0) begin n_fail++; $display("FAIL reset_finish_ksa sel%0d: got %b, need 0", s, m_finksa); end
        end
        sel = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Fixed 2-cycle memory: early swaps, final S, op count, pulse width and total latency.
    task automatic test_full_run();
        int exp_a [6] = '{0, 0, 1, 3, 8'h02, 8'h4E};
        int exp_d [6] = '{0, 0, 3, 1, 8'h4E, 8'h02};
        sel = 1'b0; key3 = 24'h000249; key_b[0] = 8'h00; key_b[1] = 8'h02; key_b[2] = 8'h49;
        lat_mode = 2;
        init_identity(); clear_stats(); gold_ksa(3);
        pulse_start();
        wait_fin(1, "full_run");
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (wq_a.size() <= k || wq_a[k] !== 8'(exp_a[k]) || wq_d[k] !== 8'(exp_d[k])) begin
                n_fail++;
                $display("FAIL early_write%0d: got addr %h data %h, need addr %h data %h", k,
                         (wq_a.size() > k) ? wq_a[k] : 8'hxx, (wq_d.size() > k) ? wq_d[k] : 8'hxx,
                         8'(exp_a[k]), 8'(exp_d[k]));
            end
        end
        n_cmp++; if (s_diff() != 0)    begin n_fail++; $display("FAIL full_run_S: %0d bytes differ, need 0", s_diff()); end
        n_cmp++; if (start_cnt != 1024) begin n_fail++; $display("FAIL full_run_ops: got %0d, need 1024", start_cnt); end
        n_cmp++; if (fin_cnt != 1)      begin n_fail++; $display("FAIL full_run_finish_count: got %0d, need 1", fin_cnt); end
        n_cmp++; if (fin_wid_bad != 0)  begin n_fail++; $display("FAIL full_run_finish_width: %0d extra high cycles, need 0", fin_wid_bad); end
        n_cmp++; if (viol != 0)         begin n_fail++; $display("FAIL full_run_protocol: %0d violations, need 0", viol); end
        n_cmp++;
        if (fin_cyc_q.size() < 1 || start_cyc_q.size() < 1 || fin_cyc_q[0] - start_cyc_q[0] != 256 * (4 * 3 + 2)) begin
            n_fail++;
            $display("FAIL full_run_latency: got %0d, need %0d",
                     (fin_cyc_q.size() > 0 && start_cyc_q.size() > 0) ? fin_cyc_q[0] - start_cyc_q[0] : -1, 256 * 14);
        end
    endtask

    task automatic test_var_latency();
        lat_mode = 0;
        init_identity(); clear_stats(); gold_ksa(3);
        pulse_start();
        wait_fin(1, "var_latency");
        n_cmp++; if (s_diff() != 0)     begin n_fail++; $display("FAIL var_lat_S: %0d bytes differ, need 0", s_diff()); end
        n_cmp++; if (viol != 0)         begin n_fail++; $display("FAIL var_lat_protocol: %0d violations, need 0", viol); end
        n_cmp++; if (start_cnt != 1024) begin n_fail++; $display("FAIL var_lat_ops: got %0d, need 1024", start_cnt); end
    endtask

    task automatic test_back_to_back();
        lat_mode = 2;
        init_identity(); clear_stats(); gold_ksa(3); gold_ksa(3);
        @(negedge clk);
        start_ksa = 1'b1;
        wait_fin(1, "b2b_first");
        start_ksa = 1'b0;
        wait_fin(2, "b2b_second");
        n_cmp++; if (s_diff() != 0)     begin n_fail++; $display("FAIL b2b_S: %0d bytes differ, need 0", s_diff()); end
        n_cmp++; if (start_cnt != 2048) begin n_fail++; $display("FAIL b2b_ops: got %0d, need 2048", start_cnt); end
        n_cmp++;
        if (start_cyc_q.size() < 1025 || fin_cyc_q.size() < 1 || start_cyc_q[1024] != fin_cyc_q[0] + 2) begin
            n_fail++;
            $display("FAIL b2b_restart_gap: got %0d, need 2",
                     (start_cyc_q.size() >= 1025 && fin_cyc_q.size() > 0) ? start_cyc_q[1024] - fin_cyc_q[0] : -1);
        end
    endtask

    // Reset asserted while the RD_SJ read at i=40 is outstanding; its late finish must be ignored.
    task automatic test_reset_mid_run();
        int c = 0;
        int starts_at_reset;
        int deliv_at_reset;
        lat_mode = 6;
        init_identity(); clear_stats();
        pulse_start();
        while (start_cnt < 162 && c < 20000) begin
            @(negedge clk); #1;
            c++;
        end
        n_cmp++; if (start_cnt != 162) begin n_fail++; $display("FAIL midreset_reach: start count %0d, need 162", start_cnt); end
        mon_en = 1'b0;
        starts_at_reset = start_cnt;
        deliv_at_reset = fin_deliv;
        reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (m_addr !== 8'h00 || m_dout !== 8'h00 || m_rw !== 1'b0 || m_start !== 1'b0 || m_finksa !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got addr %h data %h rw %b start %b fin %b, need all 0", m_addr, m_dout, m_rw, m_start, m_finksa);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        n_cmp++; if (fin_deliv != deliv_at_reset + 1) begin n_fail++; $display("FAIL midreset_late_finish: delivered %0d, need %0d", fin_deliv - deliv_at_reset, 1); end
        n_cmp++; if (start_cnt != starts_at_reset) begin n_fail++; $display("FAIL midreset_no_new_op: got %0d extra ops, need 0", start_cnt - starts_at_reset); end
        n_cmp++; if (fin_cnt != 0 || m_addr !== 8'h00) begin n_fail++; $display("FAIL midreset_idle: fin %0d addr %h, need 0 and 00", fin_cnt, m_addr); end
        mon_en = 1'b1;
    endtask

    task automatic test_key_len1();
        sel = 1'b1; key1 = 8'hFF; key_b[0] = 8'hFF;
        lat_mode = 0;
        @(negedge clk);
        init_identity(); clear_stats(); gold_ksa(1);
        pulse_start();
        wait_fin(1, "key_len1");
        n_cmp++; if (s_diff() != 0)     begin n_fail++; $display("FAIL keylen1_S: %0d bytes differ, need 0", s_diff()); end
        n_cmp++; if (start_cnt != 1024) begin n_fail++; $display("FAIL keylen1_ops: got %0d, need 1024", start_cnt); end
        n_cmp++; if (viol != 0)         begin n_fail++; $display("FAIL keylen1_protocol: %0d violations, need 0", viol); end
        n_cmp++; if (fin_wid_bad != 0 || fin_cnt != 1) begin n_fail++; $display("FAIL keylen1_finish: count %0d extra %0d, need 1 and 0", fin_cnt, fin_wid_bad); end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_var_latency();
        test_back_to_back();
        test_reset_mid_run();
        test_key_len1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ksa_shuffle.md
Name: ksa_shuffle

Overview:
- Second stage of the RC4 key-scheduling algorithm, directly downstream of the S-memory initialisation stage.
- Starts after S holds the identity permutation (S[k]=k). For i=0..255 it computes j = j + S[i] + key[i mod KEY_LEN] (mod 256), then swaps S[i] and S[j].
- Reaches S memory through the shared memory-interface handshake (start_readWrite_op / finish_readWrite_op).
- Uses the start/finish protocol to chain to the next stage (PRGA decrypt).

Parameters:
- KEY_LEN, 3, number of key bytes; legal range 1..16.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- secret_key  input  8*KEY_LEN  key; key byte 0 = secret_key[8*KEY_LEN-1 -: 8] (MSB-first). Must be held stable from start_ksa to finish_ksa.
- address  output  8  S-memory address.
- data_out  output  8  S-memory write data.
- data_in  input  8  S-memory read data; valid in the cycle finish_readWrite_op=1 for a read.
- readWrite  output  1  1=write, 0=read.
- start_readWrite_op  output  1  one-cycle request pulse to the memory interface.
- finish_readWrite_op  input  1  one-cycle completion pulse from the memory interface.
- start_ksa  input  1  start request (level or pulse).
- finish_ksa  output  1  one-cycle done pulse.

Behaviour:
- Reset (reset=0 at a clock edge):
  - address, data_out, readWrite, start_readWrite_op and finish_ksa go to 0.
  - Internal i, j, si, sj go to 0; state goes to IDLE.
  - Reset mid-operation aborts immediately. Any memory op in flight is abandoned; its finish pulse arriving in IDLE is ignored.
- Registers:
  - i: 8 bits.
  - j: 8 bits; all arithmetic is mod 256 (natural 8-bit wrap).
  - si, sj: 8-bit latched S values.
  - key index = i mod KEY_LEN, computed with a wrapping counter (no divider). It resets to 0 with i and increments with i, returning to 0 at KEY_LEN-1.
- Memory op rule: a state issuing an op sets address, data_out and readWrite, and pulses start_readWrite_op for exactly one cycle. address, data_out and readWrite stay stable until finish_readWrite_op. Only one op is outstanding at a time.
- State machine:
  - IDLE: outputs 0, i=j=0, key index 0. start_ksa=1 -> RD_SI.
  - RD_SI: read address=i -> WT_SI.
  - WT_SI: on finish, si<=data_in -> CALC_J.
  - CALC_J: j <= j + si + key[kidx] -> RD_SJ (one cycle).
  - RD_SJ: read address=j (the new j) -> WT_SJ.
  - WT_SJ: on finish, sj<=data_in -> WR_SI.
  - WR_SI: write address=i, data_out=sj -> WT_WSI.
  - WT_WSI: on finish -> WR_SJ.
  - WR_SJ: write address=j, data_out=si -> WT_WSJ.
  - WT_WSJ: on finish -> INCR.
  - INCR: i==255 -> FINISH; otherwise i++, kidx wraps -> RD_SI.
  - FINISH: finish_ksa=1 for one cycle; all other outputs 0 -> IDLE.
- i==j case: the full sequence still runs (both writes to the same address, same value). This leaves S unchanged.
- start_ksa is ignored outside IDLE. If start_ksa is still high in the cycle after FINISH, a new run starts.
- Per-iteration cost: 4 memory ops + 2 internal cycles (CALC_J, INCR). The 256 iterations total exactly 1024 memory ops.
- Latency with a fixed N-cycle memory latency (finish N cycles after start): 256*(4*(N+1)+2) cycles from the RD_SI entry to FINISH, plus one IDLE cycle.

Test Plan:
- Reset low for 2 cycles mid-run (e.g. during WT_SJ at i=40) -> all outputs 0 next edge, state IDLE; a late finish_readWrite_op is ignored; no further start_readWrite_op without start_ksa.
- Identity S, secret_key=24'h000249, KEY_LEN=3, 2-cycle mock memory -> i=0: j=0, writes S[0]=0 twice. i=1: j=3, S[1]=3, S[3]=1. i=2: j=0x4E, S[2]=0x4E, S[0x4E]=2.
- Full run, same key -> final 256-byte S matches a golden software KSA model; exactly 1024 start_readWrite_op pulses; finish_ksa high exactly one cycle.
- Variable memory latency (random 1-6 cycles) -> identical final S. start_readWrite_op never re-pulses before the prior finish. address, data_out and readWrite are stable while each op is pending.
- start_ksa held high across FINISH -> a second KSA run begins on the first IDLE cycle. Final S equals a double application of KSA (golden model).
- KEY_LEN=1, secret_key=8'hFF -> key index stays 0; j increments by S[i]+0xFF each step; final S matches the golden model.
